// File: rtl/qed_dup_scheduler.sv
// qed_dup_scheduler
//
// Instruction scheduler for quick error detection by duplication. It runs in two phases.
//
// In the original phase, fetched instructions pass straight through to the pipeline.
// Every non-NOP instruction is also recorded in a FIFO.
//
// In the duplicate phase, the FIFO is drained in order. Each entry is reissued with its
// register fields moved into the upper register bank (x16-x31), and with load/store
// addresses moved 1 KiB up. This way the copy works on a disjoint register set and a
// disjoint memory region. When the FIFO is empty the scheduler parks in DONE until reset.
// In DONE the two register banks can be compared.
//
// Ports
//   clk              clock, rising edge
//   reset_x          asynchronous active-low reset
//   ifu_instruction  instruction from fetch (R/I/LW/SW/NOP subset, x0-x15)
//   ifu_valid        ifu_instruction is valid
//   stall            pipeline back-pressure; freezes the whole scheduler
//   exec_dup         end the original phase and start duplicating
//   ifu_ready        instruction accepted this cycle when ifu_valid is high
//   qed_instruction  registered instruction to the pipeline (NOP when idle)
//   qed_valid        qed_instruction is a real instruction, not a bubble
//   qed_mode         0 in the original phase, 1 in the duplicate or done phase
//   qed_ready        every queued original has been duplicated
//   orig_count       originals queued so far
//   dup_count        duplicates issued so far
module qed_dup_scheduler #(
  parameter int unsigned QDEPTH = 16
) (
  input  logic                    clk,
  input  logic                    reset_x,
  input  logic [31:0]             ifu_instruction,
  input  logic                    ifu_valid,
  input  logic                    stall,
  input  logic                    exec_dup,
  output logic                    ifu_ready,
  output logic [31:0]             qed_instruction,
  output logic                    qed_valid,
  output logic                    qed_mode,
  output logic                    qed_ready,
  output logic [$clog2(QDEPTH):0] orig_count,
  output logic [$clog2(QDEPTH):0] dup_count
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [CW-1:0] DepthC = CW'(QDEPTH);
  localparam logic [CW-1:0] LastC  = CW'(QDEPTH - 1);

  localparam logic [31:0] NopInstr = 32'h0000007F;
  localparam logic [6:0]  OpNop    = 7'b1111111;
  localparam logic [6:0]  OpR      = 7'b0110011;
  localparam logic [6:0]  OpI      = 7'b0010011;
  localparam logic [6:0]  OpLw     = 7'b0000011;
  localparam logic [6:0]  OpSw     = 7'b0100011;

  localparam logic [1:0] StOrig = 2'd0;
  localparam logic [1:0] StDup  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] orig_count_q, orig_count_d;
  logic [CW-1:0] dup_count_q, dup_count_d;
  logic [31:0]   instr_q, instr_d;
  logic          valid_q, valid_d;
  logic          ready_q;

  logic [31:0] queue_mem [QDEPTH];

  logic full, empty, accept, push;

  // Move the copy to the upper register bank.
  // Loads and stores use x0 as base, so setting imm[10] (instr[30]) shifts the address
  // into a separate 1 KiB window.
  function automatic logic [31:0] remap(input logic [31:0] instr);
    logic [31:0] r;
    r = instr;
    case (instr[6:0])
      OpR: begin
        r[11] = 1'b1;
        r[19] = 1'b1;
        r[24] = 1'b1;
      end
      OpI: begin
        r[11] = 1'b1;
        r[19] = 1'b1;
      end
      OpLw: begin
        r[11] = 1'b1;
        r[30] = 1'b1;
      end
      OpSw: begin
        r[24] = 1'b1;
        r[30] = 1'b1;
      end
      default: r = instr;
    endcase
    return r;
  endfunction

  // Counts only ever grow during a run, so their difference is the FIFO occupancy.
  assign full      = (orig_count_q == DepthC);
  assign empty     = (orig_count_q == dup_count_q);
  assign ifu_ready = (state_q == StOrig) && !full && !stall;
  assign accept    = ifu_valid && ifu_ready;
  assign push      = accept && (ifu_instruction[6:0] != OpNop);

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    orig_count_d = orig_count_q;
    dup_count_d  = dup_count_q;
    instr_d      = NopInstr;
    valid_d      = 1'b0;
    case (state_q)
      StOrig: begin
        if (accept) begin
          instr_d = ifu_instruction;
          valid_d = 1'b1;
        end
        if (push) begin
          wr_ptr_d     = wr_ptr_q + 1'b1;
          orig_count_d = orig_count_q + 1'b1;
        end
        // A push that fills the FIFO ends the original phase on the same edge.
        if (exec_dup || full || (push && (orig_count_q == LastC))) begin
          state_d = StDup;
        end
      end
      StDup: begin
        if (!empty) begin
          instr_d     = remap(queue_mem[rd_ptr_q]);
          valid_d     = 1'b1;
          rd_ptr_d    = rd_ptr_q + 1'b1;
          dup_count_d = dup_count_q + 1'b1;
        end else begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StDone;
      default: state_d = StOrig;
    endcase
  end

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state_q      <= StOrig;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      orig_count_q <= '0;
      dup_count_q  <= '0;
      instr_q      <= NopInstr;
      valid_q      <= 1'b0;
      ready_q      <= 1'b0;
    end else if (!stall) begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      orig_count_q <= orig_count_d;
      dup_count_q  <= dup_count_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
      ready_q      <= (state_d == StDone);
    end
  end

  // FIFO storage needs no reset: occupancy comes from the counters alone.
  always_ff @(posedge clk) begin
    if (push) begin
      queue_mem[wr_ptr_q] <= ifu_instruction;
    end
  end

  assign qed_instruction = instr_q;
  assign qed_valid       = valid_q;
  assign qed_mode        = (state_q != StOrig);
  assign qed_ready       = ready_q;
  assign orig_count      = orig_count_q;
  assign dup_count       = dup_count_q;

endmodule

// File: tb/tb_qed_dup_scheduler.sv
module tb_qed_dup_scheduler;

  localparam int QD = 16;
  localparam logic [31:0] NOP = 32'h0000007F;
  localparam int PH_ORIG = 0;
  localparam int PH_DUP  = 1;
  localparam int PH_DONE = 2;

  logic        clk = 1'b0;
  logic        reset_x = 1'b0;
  logic [31:0] ifu_instruction = NOP;
  logic        ifu_valid = 1'b0;
  logic        stall = 1'b0;
  logic        exec_dup = 1'b0;
  logic        ifu_ready;
  logic [31:0] qed_instruction;
  logic        qed_valid, qed_mode, qed_ready;
  logic [4:0]  orig_count, dup_count;

  qed_dup_scheduler #(.QDEPTH(QD)) dut (
    .clk             (clk),
    .reset_x         (reset_x),
    .ifu_instruction (ifu_instruction),
    .ifu_valid       (ifu_valid),
    .stall           (stall),
    .exec_dup        (exec_dup),
    .ifu_ready       (ifu_ready),
    .qed_instruction (qed_instruction),
    .qed_valid       (qed_valid),
    .qed_mode        (qed_mode),
    .qed_ready       (qed_ready),
    .orig_count      (orig_count),
    .dup_count       (dup_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        mode;
    int          oc;
    int          dc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_q[$];
  int          m_orig, m_dup, ph;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference duplicate, built from instruction fields: registers go to the upper bank;
  // load/store addresses move up by 1024.
  function automatic logic [31:0] dup_of(input logic [31:0] ins);
    logic [6:0]  opc, hi;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] imm;
    opc = ins[6:0];
    rd  = ins[11:7];
    f3  = ins[14:12];
    rs1 = ins[19:15];
    rs2 = ins[24:20];
    hi  = ins[31:25];
    imm = ins[31:20];
    case (opc)
      7'b0110011: return {hi, rs2 | 5'h10, rs1 | 5'h10, f3, rd | 5'h10, opc};
      7'b0010011: return {imm, rs1 | 5'h10, f3, rd | 5'h10, opc};
      7'b0000011: return {imm | 12'h400, rs1, f3, rd | 5'h10, opc};
      7'b0100011: return {hi | 7'h20, rs2 | 5'h10, rs1, f3, rd, opc};
      default:    return ins;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr(input bit allow_nop);
    int          k;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] imm;
    k   = $urandom_range(allow_nop ? 4 : 3, 0);
    rd  = 5'($urandom_range(15, 0));
    rs1 = 5'($urandom_range(15, 0));
    rs2 = 5'($urandom_range(15, 0));
    f3  = 3'($urandom_range(7, 0));
    case (k)
      0: return {($urandom_range(1, 0) != 0) ? 7'h20 : 7'h00, rs2, rs1, f3, rd, 7'b0110011};
      1: return {12'($urandom_range(4095, 0)), rs1, f3, rd, 7'b0010011};
      2: begin
        imm = 12'($urandom_range(255, 0) * 4);
        return {imm, 5'd0, 3'b010, rd, 7'b0000011};
      end
      3: begin
        imm = 12'($urandom_range(255, 0) * 4);
        return {imm[11:5], rs2, 5'd0, 3'b010, imm[4:0], 7'b0100011};
      end
      default: return NOP;
    endcase
  endfunction

  // Drive one cycle from posedge+1, update the model for the coming edge, return at posedge+1.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic st, input logic ex);
    logic exp_rdy;
    bit   acc;
    exp_t e;
    ifu_valid       = v;
    ifu_instruction = ins;
    stall           = st;
    exec_dup        = ex;
    #1;
    exp_rdy = (ph == PH_ORIG) && (m_orig < QD) && !st;
    check("ifu_ready", ifu_ready, exp_rdy);
    acc = 1'b0;
    if (!st) begin
      if (ph == PH_ORIG) begin
        if (v && exp_rdy) begin
          acc = 1'b1;
          if (ins[6:0] != 7'h7F) begin
            m_q.push_back(ins);
            m_orig++;
          end
        end
        if (ex || m_orig == QD) ph = PH_DUP;
        if (acc) begin
          e = '{instr: ins, mode: (ph != PH_ORIG), oc: m_orig, dc: m_dup};
          exp_q.push_back(e);
        end
      end else if (ph == PH_DUP) begin
        if (m_q.size() > 0) begin
          m_dup++;
          e = '{instr: dup_of(m_q.pop_front()), mode: 1'b1, oc: m_orig, dc: m_dup};
          exp_q.push_back(e);
        end else begin
          ph = PH_DONE;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2;
    reset_x = 1'b0;
    m_q.delete();
    exp_q.delete();
    m_orig = 0;
    m_dup  = 0;
    ph     = PH_ORIG;
    ifu_valid = 1'b0;
    ifu_instruction = NOP;
    stall = 1'b0;
    exec_dup = 1'b0;
    #1;
    check("reset instr", qed_instruction, NOP);
    check("reset valid/mode/ready", {qed_valid, qed_mode, qed_ready}, 3'b000);
    check("reset counts", {orig_count, dup_count}, 10'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_x = 1'b1;
  endtask

  task automatic run_to_done(input bit rnd_stall);
    for (int i = 0; i < 200 && qed_ready !== 1'b1; i++) begin
      cycle(1'($urandom_range(1, 0)), rand_instr(1'b1),
            rnd_stall ? ($urandom_range(3, 0) == 0) : 1'b0, 1'b1);
    end
    check("reach done", qed_ready, 1'b1);
  endtask

  task automatic check_done();
    check("done mode", qed_mode, 1'b1);
    check("done bubble", {qed_valid, qed_instruction}, {1'b0, NOP});
    check("done counts", {orig_count, dup_count}, {5'(m_orig), 5'(m_dup)});
    check("done counts equal", orig_count, dup_count);
    check("done ifu_ready", ifu_ready, 1'b0);
    check("pending outputs", exp_q.size(), 0);
  endtask

  // Monitor: compares each new valid output with the scoreboard; checks freeze under stall.
  logic        edge_stall = 1'b0;
  logic        edge_live = 1'b0;
  logic [31:0] p_instr;
  logic        p_valid;
  logic [9:0]  p_counts;
  exp_t        mon_e;

  always @(posedge clk) begin
    edge_stall <= stall;
    edge_live  <= reset_x;
  end

  always @(negedge clk) begin
    if (reset_x && edge_live) begin
      if (edge_stall) begin
        check("stall hold instr", qed_instruction, p_instr);
        check("stall hold valid/counts", {qed_valid, orig_count, dup_count},
              {p_valid, p_counts});
      end else if (qed_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected output", qed_instruction, NOP);
          check("unexpected valid", qed_valid, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          check("out instr", qed_instruction, mon_e.instr);
          check("out mode/counts", {qed_mode, orig_count, dup_count},
                {mon_e.mode, 5'(mon_e.oc), 5'(mon_e.dc)});
        end
      end else begin
        check("bubble instr", qed_instruction, NOP);
      end
    end
    p_instr  <= qed_instruction;
    p_valid  <= qed_valid;
    p_counts <= {orig_count, dup_count};
  end

  initial begin
    #900000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    // ADD round trip
    do_reset();
    cycle(1'b1, 32'h002081B3, 1'b0, 1'b0);
    check("add original", {qed_valid, qed_instruction}, {1'b1, 32'h002081B3});
    cycle(1'b0, NOP, 1'b0, 1'b1);
    cycle(1'b0, NOP, 1'b0, 1'b0);
    check("add duplicate", {qed_valid, qed_instruction}, {1'b1, 32'h012889B3});
    run_to_done(1'b0);
    check_done();
    check("add counts", {orig_count, dup_count}, {5'd1, 5'd1});

    // LW then SW
    do_reset();
    cycle(1'b1, 32'h00402283, 1'b0, 1'b0);
    cycle(1'b1, 32'h00502423, 1'b0, 1'b0);
    cycle(1'b0, NOP, 1'b0, 1'b1);
    cycle(1'b0, NOP, 1'b0, 1'b0);
    check("lw duplicate", qed_instruction, 32'h40402A83);
    cycle(1'b0, NOP, 1'b0, 1'b0);
    check("sw duplicate", qed_instruction, 32'h41502423);
    run_to_done(1'b0);
    check_done();

    // Fill the queue without exec_dup
    do_reset();
    for (int i = 0; i < QD; i++) cycle(1'b1, rand_instr(1'b0), 1'b0, 1'b0);
    check("ready after full", {ifu_ready, qed_mode}, 2'b01);
    run_to_done(1'b0);
    check_done();
    check("full dup_count", dup_count, 5'd16);

    // Stall during the duplicate phase
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, rand_instr(1'b0), 1'b0, 1'b0);
    cycle(1'b0, NOP, 1'b0, 1'b1);
    cycle(1'b0, NOP, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, rand_instr(1'b0), 1'b1, 1'b1);
    check("stall dup_count", dup_count, 5'd1);
    run_to_done(1'b0);
    check_done();

    // NOP only, empty queue
    do_reset();
    cycle(1'b1, NOP, 1'b0, 1'b0);
    check("nop issued", {qed_valid, qed_instruction}, {1'b1, NOP});
    cycle(1'b0, NOP, 1'b0, 1'b1);
    cycle(1'b0, NOP, 1'b0, 1'b0);
    check("nop done", qed_ready, 1'b1);
    check_done();
    check("nop counts", {orig_count, dup_count}, 10'd0);

    // Reset in the middle of duplication
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, rand_instr(1'b0), 1'b0, 1'b0);
    cycle(1'b0, NOP, 1'b0, 1'b1);
    cycle(1'b0, NOP, 1'b0, 1'b0);
    cycle(1'b0, NOP, 1'b0, 1'b0);
    do_reset();
    cycle(1'b1, 32'h002081B3, 1'b0, 1'b0);
    cycle(1'b1, rand_instr(1'b0), 1'b0, 1'b0);
    check("after reset counts", orig_count, 5'd2);
    run_to_done(1'b0);
    check_done();

    // Randomized runs
    for (int r = 0; r < 12; r++) begin
      do_reset();
      for (int i = 0; i < 40; i++) begin
        cycle(($urandom_range(3, 0) != 0), rand_instr(1'b1), ($urandom_range(4, 0) == 0),
              ($urandom_range(15, 0) == 0));
      end
      run_to_done(1'b1);
      check_done();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
